// File: rtl/seg_capture.sv
`default_nettype none
// ============================================================================
// Module   : seg_capture
// Brief    : Recovers a 4-digit hex value from a multiplexed 7-segment scan.
//            Optional decimal-point capture when SEG_CAPTURE_DP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module seg_capture #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] value,
  output logic        valid,
  output logic        frame_err,
  output logic [3:0]  dp
);

  localparam int c_idle_w = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_idle_w-1:0] c_timeout     = c_idle_w'(TIMEOUT_CYCLES);
  localparam logic [7:0]          c_stable_last = 8'(STABLE_CYCLES - 1);
`ifdef SEG_CAPTURE_DP_EN
  localparam logic [7:0] c_seg_mask = 8'hFF;
`else
  // Without dp capture the dp line must not disturb settling either.
  localparam logic [7:0] c_seg_mask = 8'h7F;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_an_snap;
  logic [7:0]            r_seg_snap;
  logic [7:0]            r_stab_cnt;
  logic [c_idle_w-1:0]   r_idle_cnt;
  logic [3:0]            r_mask, r_err;
  logic [15:0]           r_shadow, r_value;
  logic                  r_frame_err, r_valid;

  logic                  w_an_valid, w_same, w_an_same;
  logic                  w_snap, w_cnt_inc, w_sample, w_complete, w_timeout;
  logic [1:0]            w_idx;
  logic [4:0]            w_dec;
  logic [3:0]            w_mask_m, w_err_m;
  logic [15:0]           w_shadow_m;

  // Returns {err, nibble}; undecodable patterns give err=1, nibble=0.
  function automatic logic [4:0] f_decode(input logic [6:0] s);
    case (s)
      7'h40:   f_decode = 5'h00;
      7'h79:   f_decode = 5'h01;
      7'h24:   f_decode = 5'h02;
      7'h30:   f_decode = 5'h03;
      7'h19:   f_decode = 5'h04;
      7'h12:   f_decode = 5'h05;
      7'h02:   f_decode = 5'h06;
      7'h78:   f_decode = 5'h07;
      7'h00:   f_decode = 5'h08;
      7'h10:   f_decode = 5'h09;
      7'h08:   f_decode = 5'h0A;
      7'h03:   f_decode = 5'h0B;
      7'h46:   f_decode = 5'h0C;
      7'h21:   f_decode = 5'h0D;
      7'h06:   f_decode = 5'h0E;
      7'h0E:   f_decode = 5'h0F;
      default: f_decode = 5'h10;
    endcase
  endfunction

  assign w_an_valid = (an == 4'b1110) || (an == 4'b1101) ||
                      (an == 4'b1011) || (an == 4'b0111);
  assign w_an_same  = (an == r_an_snap);
  assign w_same     = w_an_same && ((seg & c_seg_mask) == r_seg_snap);
  assign w_timeout  = (r_state == S_IDLE) && (r_idle_cnt == c_timeout);
  assign w_dec      = f_decode(r_seg_snap[6:0]);

  always_comb begin
    case (r_an_snap)
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_idx = 2'd0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_snap      = 1'b0;
    w_cnt_inc   = 1'b0;
    w_sample    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_an_valid) begin
          w_snap      = 1'b1;
          w_state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (!w_same) begin
          w_snap      = 1'b1;
          w_state_nxt = w_an_valid ? S_SETTLE : S_IDLE;
        end else if (r_stab_cnt == c_stable_last) begin
          w_sample    = 1'b1;
          w_state_nxt = S_HOLD;
        end else begin
          w_cnt_inc   = 1'b1;
        end
      end
      S_HOLD: begin
        if (!w_an_same) begin
          w_snap      = 1'b1;
          w_state_nxt = w_an_valid ? S_SETTLE : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Merge the digit being sampled so completion can load in the same edge.
  always_comb begin
    w_shadow_m = r_shadow;
    w_err_m    = r_err;
    w_mask_m   = r_mask;
    if (w_sample) begin
      w_shadow_m[{w_idx, 2'b00} +: 4] = w_dec[3:0];
      w_err_m[w_idx]                  = w_dec[4];
      w_mask_m[w_idx]                 = 1'b1;
    end
  end

  assign w_complete = w_sample && (w_mask_m == 4'hF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_an_snap   <= '0;
      r_seg_snap  <= '0;
      r_stab_cnt  <= '0;
      r_idle_cnt  <= '0;
      r_mask      <= '0;
      r_err       <= '0;
      r_shadow    <= '0;
      r_value     <= '0;
      r_frame_err <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_valid  <= w_complete;
      r_shadow <= w_shadow_m;
      if (w_snap) begin
        r_an_snap  <= an;
        r_seg_snap <= seg & c_seg_mask;
        r_stab_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_stab_cnt <= r_stab_cnt + 8'd1;
      end
      if ((r_state != S_IDLE) || w_an_valid) begin
        r_idle_cnt <= '0;
      end else if (r_idle_cnt != c_timeout) begin
        r_idle_cnt <= r_idle_cnt + 1'b1;
      end
      if (w_complete) begin
        r_value     <= w_shadow_m;
        r_frame_err <= |w_err_m;
        r_mask      <= '0;
        r_err       <= '0;
      end else if (w_timeout) begin
        r_mask <= '0;
        r_err  <= '0;
      end else begin
        r_mask <= w_mask_m;
        r_err  <= w_err_m;
      end
    end
  end

`ifdef SEG_CAPTURE_DP_EN
  logic [3:0] r_dp_slot, r_dp, w_dp_m;

  always_comb begin
    w_dp_m = r_dp_slot;
    if (w_sample) w_dp_m[w_idx] = ~r_seg_snap[7];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp_slot <= '0;
      r_dp      <= '0;
    end else begin
      r_dp_slot <= w_dp_m;
      if (w_complete) r_dp <= w_dp_m;
    end
  end

  assign dp = r_dp;
`else
  assign dp = 4'b0000;
`endif

  assign value     = r_value;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_seg_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_capture
// Brief    : Directed scans plus randomized scan traffic against a frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_capture;

  localparam int STABLE = 4;
  localparam int TOUT   = 16;
`ifdef SEG_CAPTURE_DP_EN
  localparam logic [7:0] SEGM = 8'hFF;
  localparam bit         DPEN = 1'b1;
`else
  localparam logic [7:0] SEGM = 8'h7F;
  localparam bit         DPEN = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  seg   = 8'hFF;
  logic [3:0]  an    = 4'hF;
  logic [15:0] value;
  logic        valid, frame_err;
  logic [3:0]  dp;

  seg_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .an(an),
    .value(value), .valid(valid), .frame_err(frame_err), .dp(dp)
  );

  always #5 clk = ~clk;

  // Active-low segment patterns for hex digits 0..F (gfedcba).
  logic [6:0] tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_chk = 0, n_pass = 0, n_valid = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Frame model: a digit is captured once per anode visit, after the
  // (an,seg) pair has been seen unchanged on STABLE+1 consecutive edges.
  logic [3:0]  m_pan, m_mask, m_err, m_dp;
  logic [7:0]  m_pseg;
  logic [3:0]  m_val [4];
  bit          m_have, m_done;
  int          m_run, m_gap;
  logic [15:0] e_value;
  logic [3:0]  e_dp;
  logic        e_err, e_valid;

  function automatic int onecold(input logic [3:0] a);
    int z = 0, idx = -1;
    for (int i = 0; i < 4; i++) if (!a[i]) begin z++; idx = i; end
    return (z == 1) ? idx : -1;
  endfunction

  task automatic model_reset();
    m_have = 0; m_done = 0; m_run = 0; m_gap = 0;
    m_pan = 4'hF; m_pseg = 8'h00; m_mask = 0; m_err = 0; m_dp = 0;
    for (int i = 0; i < 4; i++) m_val[i] = 0;
    e_value = 0; e_dp = 0; e_err = 0; e_valid = 0;
  endtask

  task automatic model_step(input logic [3:0] a, input logic [7:0] s);
    logic [7:0] sm;
    int idx;
    sm = s & SEGM;
    e_valid = 0;
    if (m_have && a == m_pan && sm == m_pseg) m_run++; else m_run = 1;
    if (!m_have || a != m_pan) m_done = 0;
    m_have = 1; m_pan = a; m_pseg = sm;
    idx = onecold(a);
    if (idx < 0) m_gap++; else m_gap = 0;
    if (m_gap >= TOUT + 2) m_mask = 0;
    if (idx >= 0 && !m_done && m_run == STABLE + 1) begin
      m_done = 1;
      m_val[idx] = 4'h0;
      m_err[idx] = 1'b1;
      for (int k = 0; k < 16; k++)
        if (tab[k] == s[6:0]) begin m_val[idx] = 4'(k); m_err[idx] = 1'b0; end
      m_dp[idx]   = DPEN ? ~s[7] : 1'b0;
      m_mask[idx] = 1'b1;
      if (m_mask == 4'hF) begin
        e_value = {m_val[3], m_val[2], m_val[1], m_val[0]};
        e_err   = |m_err;
        e_dp    = m_dp;
        e_valid = 1;
        m_mask  = 0;
      end
    end
  endtask

  task automatic step(input logic [3:0] a, input logic [7:0] s);
    an = a; seg = s;
    if (rst_n) model_step(a, s); else model_reset();
    @(negedge clk);
    check("valid", valid, e_valid);
    check("value", value, e_value);
    check("frame_err", frame_err, e_err);
    check("dp", dp, e_dp);
    if (valid) n_valid++;
  endtask

  task automatic dwell(input logic [3:0] a, input logic [7:0] s, input int n);
    for (int i = 0; i < n; i++) step(a, s);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_value", value, 0);
    check("rst_valid", valid, 0);
    check("rst_err", frame_err, 0);
    check("rst_dp", dp, 0);
    model_reset();
    step(4'hF, 8'hFF);
    step(4'hF, 8'hFF);
    rst_n = 1'b1;
  endtask

  function automatic logic [3:0] an_of(input int i);
    logic [3:0] one = 4'b0001;
    return ~(one << i);
  endfunction

  task automatic scan_digits(input logic [15:0] v, input int lo, input int hi,
                             input int cyc, input logic [3:0] dpm);
    for (int i = lo; i <= hi; i++) dwell(an_of(i), {~dpm[i], tab[v[4*i +: 4]]}, cyc);
  endtask

  initial begin
    logic [3:0] a;
    logic [7:0] s;
    bit last_idle;
    int r, len;

    @(negedge clk);
    do_reset();

    // Clean scan of 0x1234.
    n_valid = 0;
    scan_digits(16'h1234, 0, 3, 10, 4'b0000);
    dwell(4'hF, 8'hFF, 3);
    check("scan_1234_pulses", n_valid, 1);
    check("scan_1234_value", value, 16'h1234);
    check("scan_1234_err", frame_err, 0);

    // 0xABCD with digit 2 blanked, then a clean frame.
    dwell(an_of(0), {1'b1, tab[13]}, 10);
    dwell(an_of(1), {1'b1, tab[12]}, 10);
    dwell(an_of(2), 8'hFF, 10);
    dwell(an_of(3), {1'b1, tab[10]}, 10);
    dwell(4'hF, 8'hFF, 3);
    check("blank_value", value, 16'hA0CD);
    check("blank_err", frame_err, 1);
    scan_digits(16'h1234, 0, 3, 10, 4'b0000);
    dwell(4'hF, 8'hFF, 3);
    check("clean_err", frame_err, 0);

    // Glitching digit 0 completes the frame only once it settles.
    do_reset();
    n_valid = 0;
    scan_digits(16'h9876, 1, 3, 10, 4'b0000);
    for (int i = 0; i < 6; i++) dwell(an_of(0), {1'b1, tab[(i % 2) ? 5 : 6]}, 2);
    check("glitch_nosample", n_valid, 0);
    dwell(an_of(0), {1'b1, tab[6]}, 6);
    check("glitch_sampled", n_valid, 1);
    check("glitch_value", value, 16'h9876);

    // Multi-low anode is idle; long idle discards a partial frame.
    do_reset();
    n_valid = 0;
    dwell(4'b1100, {1'b1, tab[1]}, 20);
    scan_digits(16'h1111, 0, 2, 10, 4'b0000);
    dwell(4'hF, 8'hFF, 40);
    dwell(an_of(3), {1'b1, tab[1]}, 10);
    check("timeout_discard", n_valid, 0);
    scan_digits(16'h1111, 0, 2, 10, 4'b0000);
    check("timeout_refill", n_valid, 1);
    check("timeout_value", value, 16'h1111);

    // Reset in the middle of 0x5678.
    scan_digits(16'h5678, 0, 2, 10, 4'b0000);
    dwell(an_of(3), {1'b1, tab[5]}, 3);
    do_reset();
    n_valid = 0;
    dwell(an_of(3), {1'b1, tab[5]}, 10);
    check("rst_partial", n_valid, 0);
    scan_digits(16'h5678, 0, 2, 10, 4'b0000);
    check("rst_refill", n_valid, 1);
    check("rst_value_5678", value, 16'h5678);

    // Decimal point lit on digit 1 only.
    scan_digits(16'h4321, 0, 3, 10, 4'b0010);
    dwell(4'hF, 8'hFF, 3);
    check("dp_digit1", dp, DPEN ? 4'b0010 : 4'b0000);

    // Randomized scan traffic; idle stretches are either short or well past
    // the timeout so the model never depends on the exact expiry cycle.
    last_idle = 1'b1;
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 99);
      if (r == 99) begin
        do_reset();
        last_idle = 1'b1;
      end else if (r < 20 && !last_idle) begin
        do a = 4'($urandom); while (onecold(a) >= 0);
        len = (r < 4) ? $urandom_range(30, 40) : $urandom_range(1, 8);
        dwell(a, 8'($urandom), len);
        last_idle = 1'b1;
      end else begin
        a = an_of($urandom_range(0, 3));
        if ($urandom_range(0, 99) < 85) s = {1'($urandom), tab[$urandom_range(0, 15)]};
        else s = 8'($urandom);
        if ($urandom_range(0, 3) == 0)
          dwell(a, s ^ 8'(1 << $urandom_range(0, 7)), $urandom_range(1, 4));
        dwell(a, s, $urandom_range(1, 12));
        last_idle = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_capture.md
SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: cycles an/seg must hold unchanged before a digit is sampled (range 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535: idle cycles with no valid anode before the partial frame is discarded.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 seg  input  8  monitored segment bus, active-low; bit0=a .. bit6=g, bit7=dp.
REQ-006 an  input  4  monitored anode bus, active-low; an[i]=0 selects digit i.
REQ-007 value  output  16  last complete frame; digit i in value[4i+3:4i].
REQ-008 valid  output  1  one-cycle pulse when value/dp/frame_err update.
REQ-009 frame_err  output  1  held with value; 1 if any digit in the frame had an undecodable pattern.
REQ-010 dp  output  4  decimal-point state per digit, 1=lit (see Configuration).

Function
REQ-011 Anode qualification: an is valid only when exactly one bit is 0; all other an values (1111, multi-low) are idle.
REQ-012 FSM states: IDLE, SETTLE, HOLD.
REQ-013 IDLE: on valid an -> SETTLE, stability counter cleared, an/seg snapshot taken.
REQ-014 SETTLE: counter increments each cycle an and seg equal snapshot; any change -> re-snapshot, counter cleared (stay SETTLE if new an valid, else IDLE).
REQ-015 SETTLE: when counter reaches STABLE_CYCLES-1 with inputs unchanged, digit sampled that cycle -> HOLD.
REQ-016 HOLD: no further sampling; an change -> SETTLE (valid an) or IDLE (idle an); seg change alone ignored.
REQ-017 Decode seg[6:0] (gfedcba, active-low hex): 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,b=03,C=46,d=21,E=06,F=0E.
REQ-018 Undecodable pattern: nibble stored as 0, digit error flag set.
REQ-019 Sampled nibble/err/dp stored into shadow slot i; bit i set in 4-bit capture mask.
REQ-020 Resampling a digit already in mask overwrites its slot; mask unchanged.
REQ-021 When mask becomes 1111: value, dp, frame_err (OR of slot err flags) load from shadow the next cycle; valid pulses that same cycle; mask and err flags clear.
REQ-022 Capture-to-valid latency: exactly 1 cycle after the sampling cycle of the last digit.
REQ-023 Idle counter counts cycles in IDLE; at TIMEOUT_CYCLES mask and err flags clear, counter saturates; valid not asserted; any valid an resets counter.
REQ-024 value/dp/frame_err change only with valid; otherwise hold.
REQ-025 Digit order irrelevant; frame completes on the fourth distinct digit.

Reset
REQ-026 rst_n low asynchronously forces: FSM IDLE, counters 0, mask 0, shadow 0, value 0, dp 0, frame_err 0, valid 0.
REQ-027 Reset mid-frame discards partial capture; no valid pulse on or after release until a full new frame.
REQ-028 Release synchronous to clk; first sample possible STABLE_CYCLES cycles after first valid an post-release.

Configuration
REQ-029 Macro SEG_CAPTURE_DP_EN defined: dp[i] = ~seg[7] at digit i sampling, loaded with value.
REQ-030 SEG_CAPTURE_DP_EN undefined: seg[7] ignored, no dp storage, dp tied 0.

Verification
REQ-031 Drive scan of 0x1234, 10 cycles/digit, an 1110->1101->1011->0111 -> valid once, value=0x1234, frame_err=0.
REQ-032 Digit 2 seg=0x7F (blank) in frame of 0xABCD -> valid, value=0xA0CD, frame_err=1; next clean frame -> frame_err=0.
REQ-033 Glitch: seg changes every 2 cycles on digit 0, STABLE_CYCLES=4 -> no sample; then holds 4 cycles -> sampled.
REQ-034 an=1100 (two low) for 20 cycles -> no sample, FSM IDLE; an=1111 held past TIMEOUT_CYCLES (set 16) after 3 digits -> mask cleared, next lone digit produces no valid.
REQ-035 rst_n low after 3 digits of 0x5678, release, resume scan -> first valid only after all 4 digits rescanned, value=0x5678; all outputs 0 during reset.
REQ-036 With SEG_CAPTURE_DP_EN, dp lit on digit 1 only -> dp=4'b0010; without macro -> dp=0.
